// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//
// Receive stage for the usb_rx pin. Deserialises 8N1 UART frames into bytes
// and presents each byte through a one-entry valid/ready holding register.
// Framing errors (stop bit low) and overruns (byte arrives while the holding
// register is still full) are reported as single-cycle pulses.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   data[7:0]  received byte, stable while valid=1
//   valid      data holds an unconsumed byte
//   ready      consumer accepts data on any cycle with valid&ready
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    one-cycle pulse: completed byte dropped, register was full
// ---------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    // Clocks per bit and the half-bit offset used to land samples mid-bit.
    localparam int N  = CLK_FREQ / BAUD;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N + 1);

    // The counter runs 0..N-1 between samples, so compare against N-1 / H-1.
    localparam logic [CW-1:0] BIT_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);

    if (N < 4) begin : g_baud_check
        $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchroniser: two flops, reset to the idle (high) line level.
    // -----------------------------------------------------------------------
    logic [1:0] rx_sync;
    logic       rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_s = rx_sync[1];

    // -----------------------------------------------------------------------
    // Receive FSM and holding register.
    //
    // The baud counter is cleared in IDLE, so on the first START cycle it
    // reads 0 and reaches H-1 exactly at cycle H after the falling edge.
    // Every later sample restarts it at 0, putting the next sample N cycles
    // on: data bit i lands at H+(i+1)*N and the stop bit at H+9*N.
    // -----------------------------------------------------------------------
    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer handshake; a byte completing this same cycle below
            // overrides this and keeps valid high with the new data.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end

                S_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            // Line went back high before mid start bit:
                            // treat as a glitch.
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        // LSB first: shift right, new bit enters at the top.
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                S_STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            // Return to IDLE immediately so a start bit
                            // directly after the stop bit is not missed.
                            state <= S_IDLE;
                            if (!valid || ready) begin
                                data  <= shift;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            // Bad stop bit: drop the byte and wait for the
                            // line to recover, so a held-low line is not
                            // read as a stream of 0x00 frames.
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                S_BREAK: begin
                    baud_cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule
